// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR tap front end.
package fir_pkg;

    localparam int unsigned NUM_TAPS  = 8;
    localparam int unsigned TAP_IDX_W = $clog2(NUM_TAPS);

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } fir_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: software fills the shadow bank, a commit
// pulse copies the whole shadow bank into the active bank in one cycle.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned COEF_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [TAP_IDX_W-1:0]       wr_addr,
    input  logic [COEF_W-1:0]          wr_data,
    input  logic                       commit,
    output logic [COEF_W*NUM_TAPS-1:0] active_flat
);

    logic [COEF_W-1:0] shadow_q [NUM_TAPS];
    logic [COEF_W-1:0] shadow_d [NUM_TAPS];
    logic [COEF_W-1:0] active_q [NUM_TAPS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
        end
    end

    // Commit copies shadow_d so a write in the same cycle is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (commit) begin
                    active_q[i] <= shadow_d[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign active_flat[g*COEF_W +: COEF_W] = active_q[g];
    end

endmodule

// File: rtl/fir_tap_frontend.sv
// FIR front end: 8-tap delay line, per-tap signed multipliers with a fixed
// two-cycle latency, and a flush FSM that pushes eight zeros through the taps.
module fir_tap_frontend
    import fir_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_W-1:0]       sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      coef_wr_en,
    input  logic [2:0]                coef_wr_addr,
    input  logic [COEF_W-1:0]         coef_wr_data,
    input  logic                      coef_commit,
    input  logic                      flush_req,
    output logic [WIDTH*NUM_TAPS-1:0] prod_flat,
    output logic                      prod_valid,
    output logic                      flush_done
);

    fir_state_e                 state_q, state_d;
    logic [TAP_IDX_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                       shift;
    logic [SAMPLE_W-1:0]        shift_data;
    logic [SAMPLE_W-1:0]        tap_q [NUM_TAPS];
    logic                       stage_valid_q;
    logic [WIDTH-1:0]           prod_d [NUM_TAPS];
    logic [WIDTH-1:0]           prod_q [NUM_TAPS];
    logic                       prod_valid_q;
    logic [COEF_W*NUM_TAPS-1:0] active_flat;

    fir_coef_bank #(
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (coef_wr_en),
        .wr_addr     (coef_wr_addr),
        .wr_data     (coef_wr_data),
        .commit      (coef_commit),
        .active_flat (active_flat)
    );

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        sample_ready = 1'b0;
        flush_done   = 1'b0;
        shift        = 1'b0;
        shift_data   = '0;
        unique case (state_q)
            StRun: begin
                sample_ready = ~rst;
                shift        = sample_valid & ~rst;
                shift_data   = sample_in;
                // A sample offered with flush_req is taken before flushing starts.
                if (flush_req) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                shift       = 1'b1;
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == TAP_IDX_W'(NUM_TAPS - 1)) begin
                    state_d    = StRun;
                    flush_done = ~rst;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else if (shift) begin
            tap_q[0] <= shift_data;
            for (int unsigned i = 1; i < NUM_TAPS; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    // Sign-extend both operands to the lane width so the product keeps full precision.
    always_comb begin
        logic [WIDTH-1:0] tap_ext;
        logic [WIDTH-1:0] coef_ext;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            tap_ext   = {{(WIDTH-SAMPLE_W){tap_q[i][SAMPLE_W-1]}}, tap_q[i]};
            coef_ext  = {{(WIDTH-COEF_W){active_flat[i*COEF_W+COEF_W-1]}},
                         active_flat[i*COEF_W +: COEF_W]};
            prod_d[i] = tap_ext * coef_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            prod_valid_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            stage_valid_q <= shift;
            prod_valid_q  <= stage_valid_q;
            if (stage_valid_q) begin
                for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_prod
        assign prod_flat[g*WIDTH +: WIDTH] = prod_q[g];
    end

    assign prod_valid = prod_valid_q;

endmodule

// File: doc/fir_tap_frontend.md
FIR_TAP_FRONTEND -- requirements
Module: fir_tap_frontend

Interface
REQ-001 Parameter SAMPLE_W, default 16: signed input sample width.
REQ-002 Parameter COEF_W, default 16: signed coefficient width.
REQ-003 Parameter WIDTH, default 32: product lane width; SHALL equal SAMPLE_W+COEF_W.
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sample_in  in  SAMPLE_W  signed input sample.
REQ-007 sample_valid  in  1  sample_in is valid this cycle.
REQ-008 sample_ready  out  1  block accepts a sample this cycle.
REQ-009 coef_wr_en  in  1  write coef_wr_data into the shadow bank.
REQ-010 coef_wr_addr  in  3  shadow tap index, 0..7.
REQ-011 coef_wr_data  in  COEF_W  signed coefficient.
REQ-012 coef_commit  in  1  one-cycle pulse: copy the shadow bank into the active bank.
REQ-013 flush_req  in  1  one-cycle pulse: push 8 zero samples through the taps.
REQ-014 prod_flat  out  WIDTH*8  eight signed products; lane i occupies bits WIDTH*(i+1)-1 down to WIDTH*i.
REQ-015 prod_valid  out  1  prod_flat is valid this cycle.
REQ-016 flush_done  out  1  one-cycle pulse when a flush completes.

Function
REQ-017 Delay line: 8 signed taps; tap[0] = newest sample; each shift moves tap[i] to tap[i+1] and discards tap[7].
REQ-018 Shift on accept: sample_valid && sample_ready (cycle N) loads sample_in into tap[0] at the end of N.
REQ-019 Products: lane i = active_coef[i] * tap[i], full precision signed at WIDTH bits with no truncation; registered at the end of N+1.
REQ-020 prod_valid SHALL be high in cycle N+2 for each shift and low otherwise; fixed latency 2 cycles; no downstream backpressure.
REQ-021 FSM states RUN and FLUSH; sample_ready = 1 only in RUN and 0 in the cycle rst is asserted.
REQ-022 RUN -> FLUSH on flush_req; sample_valid && flush_req in the same cycle: the sample is accepted first, then FLUSH is entered.
REQ-023 FLUSH: shift one zero sample per cycle for exactly 8 cycles (3-bit counter); each zero shift produces prod_valid two cycles later per REQ-020.
REQ-024 FLUSH -> RUN after the 8th zero shift; flush_done pulses in the same cycle as the 8th zero shift; flush_req during FLUSH is ignored.
REQ-025 Shadow write: coef_wr_en writes shadow[coef_wr_addr] at the end of the cycle; active bank unaffected.
REQ-026 coef_commit copies all 8 shadow entries to the active bank at the end of the cycle; a write in the same cycle is included (bypass).
REQ-027 A sample accepted in the same cycle as coef_commit SHALL use the new coefficients; earlier samples already registered as products keep the old ones.
REQ-028 coef_commit and coef_wr_en SHALL be honoured in both RUN and FLUSH.

Reset
REQ-029 While rst is high: taps, shadow and active banks, prod_flat = 0; prod_valid = 0; flush_done = 0; flush counter = 0; state = RUN.
REQ-030 rst mid-flush or mid-pipeline SHALL abort everything; no prod_valid for pre-reset samples appears after reset; sample_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-031 The package fir_pkg SHALL hold the NUM_TAPS = 8 constant and the RUN/FLUSH state encoding; the sum tree shares NUM_TAPS.
REQ-032 One sub-module, fir_coef_bank (shadow bank, active bank, commit), SHALL be used; the delay line, FSM and multipliers stay in the top level.

Verification
REQ-033 Impulse test: commit coefficients 1..8, then feed 1 followed by 7 zeros -> on the k-th prod_valid (k = 0..7), lane k = k+1 and all other lanes = 0.
REQ-034 Extreme values: coefficient -32768, sample -32768 in lane 0 -> lane 0 = 0x40000000 with no overflow.
REQ-035 Commit timing: shadow coefficients 2, commit in the same cycle as accepting sample 5 -> lane 0 = 10; the previous sample's products keep the old coefficients.
REQ-036 Flush: flush_req with sample_valid high in the same cycle (value 3) -> the 3 is accepted; sample_ready stays low for 8 cycles; flush_done pulses once; the last prod_valid shows all lanes 0.
REQ-037 Reset mid-flush: assert rst at flush cycle 4 -> all outputs 0, no flush_done, sample_ready = 1 in the cycle after rst deasserts.
